// File: rtl/pool_pkg.sv
// Shared pooling-datapath helpers: lane/count width helpers, popcount and ceil division.
package pool_pkg;

  localparam int MAX_LANES = 64;

  function automatic int laneIdxWidth(input int numPe);
    return (numPe > 1) ? $clog2(numPe) : 1;
  endfunction

  function automatic int popWidth(input int numPe);
    return $clog2(numPe + 1);
  endfunction

  // Buffer count must reach 2*numPe-1 lanes.
  function automatic int cntWidth(input int numPe);
    return $clog2(2 * numPe);
  endfunction

  function automatic int popcount(input logic [MAX_LANES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

  function automatic int ceil_a_by_b(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/pool_lane_compact.sv
// Combinational compaction of a sparse lane vector: valid lanes left-justified in lane order.
module pool_lane_compact
  import pool_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic [NUM_PE*DATA_WIDTH-1:0]     data_i,
  input  logic [NUM_PE-1:0]                mask_i,
  output logic [NUM_PE*DATA_WIDTH-1:0]     packed_o,
  output logic [$clog2(NUM_PE+1)-1:0]      count_o
);

  localparam int PW = popWidth(NUM_PE);

  int pos;

  // pos is the running prefix sum of the mask: the destination slot of lane i.
  always_comb begin
    packed_o = '0;
    pos      = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (mask_i[i]) begin
        packed_o[pos*DATA_WIDTH +: DATA_WIDTH] = data_i[i*DATA_WIDTH +: DATA_WIDTH];
        pos = pos + 1;
      end
    end
  end

  assign count_o = PW'(popcount(MAX_LANES'(mask_i)));

endmodule

// File: rtl/pool_output_packer.sv
// Packs sparse pooled lanes into dense NUM_PE-wide words; flushes a partial word on in_last.
// Optional feature: define POOL_PACK_COUNT_EN to add the out_words_o consumed-word counter.
module pool_output_packer
  import pool_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PE*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_PE-1:0]            in_mask_i,
  input  logic                         in_last_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [NUM_PE*DATA_WIDTH-1:0] out_data_o,
  output logic [NUM_PE-1:0]            out_keep_o,
  output logic                         out_last_o,
  output logic                         out_valid_o,
`ifdef POOL_PACK_COUNT_EN
  output logic [31:0]                  out_words_o,
`endif
  input  logic                         out_ready_i
);

  localparam int BUF = 2*NUM_PE - 1;
  localparam int CW  = cntWidth(NUM_PE);
  localparam int PW  = popWidth(NUM_PE);

  typedef logic [DATA_WIDTH-1:0] lane_t;

  lane_t                         buf_q [BUF];
  lane_t                         buf_d [BUF];
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          flushPending_q, flushPending_d;
  logic [NUM_PE*DATA_WIDTH-1:0]  outData_q, outData_d;
  logic [NUM_PE-1:0]             outKeep_q, outKeep_d;
  logic                          outLast_q, outLast_d;
  logic                          outValid_q, outValid_d;

  logic [NUM_PE*DATA_WIDTH-1:0]  packedLanes;
  logic [PW-1:0]                 popCnt;
  logic                          accept;
  logic                          emit;
  int                            cntI;
  int                            nEmit;
  int                            base;

  pool_lane_compact #(
    .NUM_PE     (NUM_PE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_compact (
    .data_i   (in_data_i),
    .mask_i   (in_mask_i),
    .packed_o (packedLanes),
    .count_o  (popCnt)
  );

  assign in_ready_o = (int'(cnt_q) < NUM_PE) && !flushPending_q;
  assign accept     = in_valid_i && in_ready_o;
  assign emit       = (!outValid_q || out_ready_i) &&
                      ((int'(cnt_q) >= NUM_PE) || flushPending_q);

  // Shift out the emitted lanes first, then append the new beat behind what remains.
  always_comb begin
    cntI  = int'(cnt_q);
    nEmit = 0;
    if (emit) nEmit = (cntI < NUM_PE) ? cntI : NUM_PE;
    base = cntI - nEmit;

    for (int e = 0; e < BUF; e++) begin
      buf_d[e] = (e + nEmit < BUF) ? buf_q[e + nEmit] : '0;
    end
    if (accept) begin
      for (int j = 0; j < NUM_PE; j++) begin
        if ((j < int'(popCnt)) && (base + j < BUF)) begin
          buf_d[base + j] = packedLanes[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    cnt_d = CW'(base + (accept ? int'(popCnt) : 0));

    flushPending_d = flushPending_q;
    if (emit && flushPending_q && (cntI <= NUM_PE)) flushPending_d = 1'b0;
    if (accept && in_last_i) flushPending_d = 1'b1;

    outData_d  = outData_q;
    outKeep_d  = outKeep_q;
    outLast_d  = outLast_q;
    outValid_d = outValid_q;
    if (emit) begin
      outValid_d = 1'b1;
      outData_d  = '0;
      outKeep_d  = '0;
      for (int i = 0; i < NUM_PE; i++) begin
        if (i < nEmit) begin
          outData_d[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[i];
          outKeep_d[i] = 1'b1;
        end
      end
      outLast_d = flushPending_q && (cntI <= NUM_PE);
    end else if (out_ready_i) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < BUF; e++) buf_q[e] <= '0;
      cnt_q          <= '0;
      flushPending_q <= 1'b0;
      outData_q      <= '0;
      outKeep_q      <= '0;
      outLast_q      <= 1'b0;
      outValid_q     <= 1'b0;
    end else begin
      for (int e = 0; e < BUF; e++) buf_q[e] <= buf_d[e];
      cnt_q          <= cnt_d;
      flushPending_q <= flushPending_d;
      outData_q      <= outData_d;
      outKeep_q      <= outKeep_d;
      outLast_q      <= outLast_d;
      outValid_q     <= outValid_d;
    end
  end

  assign out_data_o  = outData_q;
  assign out_keep_o  = outKeep_q;
  assign out_last_o  = outLast_q;
  assign out_valid_o = outValid_q;

`ifdef POOL_PACK_COUNT_EN
  logic [31:0] words_q;

  // Consuming the last word of a frame restarts the count instead of incrementing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_q <= '0;
    end else if (outValid_q && out_ready_i) begin
      words_q <= outLast_q ? 32'd0 : words_q + 32'd1;
    end
  end

  assign out_words_o = words_q;
`endif

endmodule

// File: tb/tb_pool_output_packer.sv
// Self-checking bench for pool_output_packer: lane-queue model plus literal word expectations.
// Define POOL_PACK_COUNT_EN to also check the out_words_o counter.
module tb_pool_output_packer;

  localparam int NUM_PE = 4;
  localparam int DW     = 16;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic [3:0]  in_mask;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
`ifdef POOL_PACK_COUNT_EN
  logic [31:0] out_words;
`endif

  int          checks = 0;
  int          passes = 0;
  int          readyMode = 0;
  int          modelWords = 0;
  bit          modelFlush = 0;
  word_t       expQ[$];
  word_t       litQ[$];
  logic [15:0] laneQ[$];
  word_t       w;
  word_t       lw;
  bit          prevHold = 0;
  logic [63:0] prevData;
  logic [3:0]  prevKeep;
  logic        prevLast;

  pool_output_packer #(
    .NUM_PE     (NUM_PE),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data_i   (in_data),
    .in_mask_i   (in_mask),
    .in_last_i   (in_last),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_keep_o  (out_keep),
    .out_last_o  (out_last),
    .out_valid_o (out_valid),
`ifdef POOL_PACK_COUNT_EN
    .out_words_o (out_words),
`endif
    .out_ready_i (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic word_t mkWord(input logic [63:0] d, input logic [3:0] k, input logic l);
    word_t r;
    r.data = d;
    r.keep = k;
    r.last = l;
    return r;
  endfunction

  function automatic void pushWord(input int n, input bit last);
    word_t r;
    r.data = '0;
    r.keep = '0;
    r.last = last;
    for (int i = 0; i < n; i++) begin
      r.data[i*16 +: 16] = laneQ.pop_front();
      r.keep[i] = 1'b1;
    end
    expQ.push_back(r);
  endfunction

  // A frame is just the ordered stream of valid lanes chopped into NUM_PE-lane words.
  function automatic void modelAccept(input logic [63:0] d, input logic [3:0] m, input bit last);
    for (int i = 0; i < NUM_PE; i++) begin
      if (m[i]) laneQ.push_back(d[i*16 +: 16]);
    end
    if (last) begin
      while (laneQ.size() > NUM_PE) pushWord(NUM_PE, 1'b0);
      pushWord(laneQ.size(), 1'b1);
    end else begin
      while (laneQ.size() >= NUM_PE) pushWord(NUM_PE, 1'b0);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      litQ.delete();
      laneQ.delete();
      modelFlush = 1'b0;
      modelWords = 0;
      prevHold   = 1'b0;
    end else begin
      if (prevHold) begin
        checkOutput("hold out_valid", 64'(out_valid), 64'd1);
        checkOutput("hold out_data", out_data, prevData);
        checkOutput("hold keep/last", 64'({out_keep, out_last}), 64'({prevKeep, prevLast}));
      end
`ifdef POOL_PACK_COUNT_EN
      checkOutput("out_words", 64'(out_words), 64'(modelWords));
`endif
      if (out_valid && out_last) modelFlush = 1'b0;
      if (modelFlush) checkOutput("in_ready during flush", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected word: got data 0x%0h keep %b, expected no word", out_data, out_keep);
        end else begin
          w = expQ.pop_front();
          checkOutput("word data", out_data, w.data);
          checkOutput("word keep", 64'(out_keep), 64'(w.keep));
          checkOutput("word last", 64'(out_last), 64'(w.last));
        end
        if (litQ.size() > 0) begin
          lw = litQ.pop_front();
          checkOutput("literal data", out_data, lw.data);
          checkOutput("literal keep", 64'(out_keep), 64'(lw.keep));
          checkOutput("literal last", 64'(out_last), 64'(lw.last));
        end
        modelWords = out_last ? 0 : modelWords + 1;
      end
      if (in_valid && in_ready) begin
        modelAccept(in_data, in_mask, in_last);
        if (in_last) modelFlush = 1'b1;
      end
      prevHold = out_valid && !out_ready;
      prevData = out_data;
      prevKeep = out_keep;
      prevLast = out_last;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic applyStimulus(input logic [3:0] m, input logic [63:0] d, input bit last);
    bit acc;
    int n;
    in_mask  = m;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      checks++;
      $display("[TB] FAIL beat accept timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((expQ.size() != 0 || litQ.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      $display("[TB] FAIL drain timeout: %0d words still expected, out_valid=%0b, expected idle", expQ.size(), out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_mask  = '0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_keep", 64'(out_keep), 64'd0);
    checkOutput("reset out_data", out_data, 64'd0);
    checkOutput("reset out_last", 64'(out_last), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
`ifdef POOL_PACK_COUNT_EN
    checkOutput("reset out_words", 64'(out_words), 64'd0);
`endif
    @(posedge clk);
    #1;

    litQ.push_back(mkWord({16'd4, 16'd3, 16'd2, 16'd1}, 4'hF, 1'b0));
    litQ.push_back(mkWord({16'd8, 16'd7, 16'd6, 16'd5}, 4'hF, 1'b0));
    litQ.push_back(mkWord({16'd12, 16'd11, 16'd10, 16'd9}, 4'hF, 1'b0));
    for (int b = 0; b < 3; b++) begin
      applyStimulus(4'hF, {16'(4*b+4), 16'(4*b+3), 16'(4*b+2), 16'(4*b+1)}, 1'b0);
    end
    waitIdle();

    litQ.push_back(mkWord({16'd4, 16'd3, 16'd2, 16'd1}, 4'hF, 1'b0));
    litQ.push_back(mkWord({16'd8, 16'd7, 16'd6, 16'd5}, 4'hF, 1'b0));
    for (int b = 0; b < 4; b++) begin
      applyStimulus(4'b0101, {16'hBEEF, 16'(2*b+2), 16'hCAFE, 16'(2*b+1)}, 1'b0);
    end
    waitIdle();

    litQ.push_back(mkWord({16'd0, 16'd3, 16'd2, 16'd1}, 4'b0111, 1'b1));
    applyStimulus(4'b0111, {16'hDEAD, 16'd3, 16'd2, 16'd1}, 1'b1);
    waitIdle();

    litQ.push_back(mkWord(64'd0, 4'b0000, 1'b1));
    applyStimulus(4'b0000, 64'h1234_5678_9ABC_DEF0, 1'b1);
    waitIdle();

    readyMode = 2;
    @(posedge clk);
    #1;
    for (int b = 0; b < 4; b++) begin
      litQ.push_back(mkWord({16'(20+4*b+4), 16'(20+4*b+3), 16'(20+4*b+2), 16'(20+4*b+1)}, 4'hF, 1'b0));
    end
    applyStimulus(4'hF, {16'd24, 16'd23, 16'd22, 16'd21}, 1'b0);
    applyStimulus(4'hF, {16'd28, 16'd27, 16'd26, 16'd25}, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("backpressure in_ready", 64'(in_ready), 64'd0);
    checkOutput("backpressure out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    fork
      begin
        repeat (7) @(posedge clk);
        #1;
        readyMode = 0;
      end
      begin
        applyStimulus(4'hF, {16'd32, 16'd31, 16'd30, 16'd29}, 1'b0);
        applyStimulus(4'hF, {16'd36, 16'd35, 16'd34, 16'd33}, 1'b0);
      end
    join
    waitIdle();

    applyStimulus(4'b0111, {16'd0, 16'd3, 16'd2, 16'd1}, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid-reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid-reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid-reset out_keep", 64'(out_keep), 64'd0);
`ifdef POOL_PACK_COUNT_EN
    checkOutput("mid-reset out_words", 64'(out_words), 64'd0);
`endif
    @(posedge clk);
    #1;
    litQ.push_back(mkWord({16'd12, 16'd11, 16'd10, 16'd9}, 4'hF, 1'b1));
    applyStimulus(4'hF, {16'd12, 16'd11, 16'd10, 16'd9}, 1'b1);
    waitIdle();

    readyMode = 1;
    for (int b = 0; b < 400; b++) begin
      applyStimulus(4'($urandom_range(0, 15)), {$urandom(), $urandom()}, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    applyStimulus(4'($urandom_range(0, 15)), {$urandom(), $urandom()}, 1'b1);
    readyMode = 0;
    waitIdle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
